// File: rtl/dvp_pattern_tx_pkg.sv
// Shared types, pattern constants and the RGB444-to-DVP byte packing for the DVP camera emulator.
package dvp_pattern_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_GRAD  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_SOLID = 2'd3;

  // Entry 0 is the leftmost bar.
  localparam logic [7:0][11:0] BAR_TABLE = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };

  function automatic logic [7:0] pack_rgb444(input logic [11:0] rgb, input logic odd_byte);
    return odd_byte ? rgb[7:0] : {4'h0, rgb[11:8]};
  endfunction

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Maps (mode, pixel x, line y, solid colour) to a registered 12-bit RGB444 pixel.
module dvp_pattern_gen
  import dvp_pattern_tx_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int CHECK_LOG2 = 3,
  parameter int XW         = 10,
  parameter int YW         = 9
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [1:0]      i_mode,
  input  logic [XW-1:0]   i_x,
  input  logic [YW-1:0]   i_y,
  input  logic [11:0]     i_solid_rgb,
  output logic [11:0]     o_rgb
);

  localparam int XBW = XW + 3;

  logic [XBW-1:0] x_times8;
  logic [7:1]     bar_ge;
  logic [2:0]     bar_idx;
  logic [3:0]     gray;
  logic           x_cell;
  logic           y_cell;
  logic [11:0]    rgb_d;
  logic [11:0]    rgb_q;

  // bar = (x*8)/H_ACTIVE, found as the number of bar edges already passed.
  assign x_times8 = {i_x, 3'b000};
  for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
    assign bar_ge[gi] = (x_times8 >= XBW'(gi * H_ACTIVE));
  end

  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (bar_ge[k]) bar_idx = 3'(k);
    end
  end

  assign gray   = 4'(i_x);
  assign x_cell = |((i_x >> CHECK_LOG2) & XW'(1));
  assign y_cell = |((i_y >> CHECK_LOG2) & YW'(1));

  always_comb begin
    rgb_d = i_solid_rgb;
    case (i_mode)
      MODE_BARS:  rgb_d = BAR_TABLE[bar_idx];
      MODE_GRAD:  rgb_d = {gray, gray, gray};
      MODE_CHECK: rgb_d = (x_cell ^ y_cell) ? 12'hFFF : 12'h000;
      default:    rgb_d = i_solid_rgb;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rgb_q <= 12'h000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign o_rgb = rgb_q;

endmodule

// File: rtl/dvp_pattern_tx.sv
// OV7670-style DVP transmitter: frame timing FSM, pattern generator and registered byte/sync outputs.
module dvp_pattern_tx
  import dvp_pattern_tx_pkg::*;
#(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int H_BLANK       = 288,
  parameter int VSYNC_LINES   = 3,
  parameter int V_BACK_LINES  = 17,
  parameter int V_FRONT_LINES = 10,
  parameter int CHECK_LOG2    = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [1:0]  i_mode,
  input  logic [11:0] i_solid_rgb,
  output logic [7:0]  o_pix_byte,
  output logic        o_vsync,
  output logic        o_href,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt
);

  localparam int L         = 2 * H_ACTIVE + H_BLANK;
  localparam int MAX_LINES = max_int(max_int(VSYNC_LINES, V_BACK_LINES),
                                     max_int(V_ACTIVE, V_FRONT_LINES));
  localparam int HW        = width_of(L);
  localparam int VW        = width_of(MAX_LINES);
  localparam int XW        = width_of(H_ACTIVE);

  state_e        state_q, state_d;
  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic [1:0]    mode_q, mode_d;
  logic [11:0]   solid_q, solid_d;
  logic [VW-1:0] last_vc;
  logic          line_end;
  logic          frame_done;
  logic          relatch;
  logic [XW-1:0] pix_x;
  logic [11:0]   rgb_s1;

  logic          vsync_s1_q, href_s1_q, odd_s1_q, busy_s1_q, done_s1_q;
  logic [7:0]    pix_q;
  logic          vsync_q, href_q, busy_q;
  logic [15:0]   fcnt_q;

  assign line_end = (hc_q == HW'(L - 1));

  always_comb begin
    state_d    = state_q;
    hc_d       = hc_q;
    vc_d       = vc_q;
    mode_d     = mode_q;
    solid_d    = solid_q;
    frame_done = 1'b0;
    relatch    = 1'b0;
    case (state_q)
      ST_VSYNC:  last_vc = VW'(VSYNC_LINES - 1);
      ST_VBACK:  last_vc = VW'(V_BACK_LINES - 1);
      ST_ACTIVE: last_vc = VW'(V_ACTIVE - 1);
      ST_VFRONT: last_vc = VW'(V_FRONT_LINES - 1);
      default:   last_vc = '0;
    endcase
    if (state_q == ST_IDLE) begin
      hc_d = '0;
      vc_d = '0;
      if (i_enable) begin
        relatch = 1'b1;
        state_d = ST_VSYNC;
      end
    end else begin
      hc_d = line_end ? '0 : hc_q + 1'b1;
      if (line_end) begin
        if (vc_q == last_vc) begin
          vc_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBACK;
            ST_VBACK:  state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFRONT;
            default: begin
              // Back-to-back frames skip IDLE entirely when still enabled.
              frame_done = 1'b1;
              if (i_enable) begin
                relatch = 1'b1;
                state_d = ST_VSYNC;
              end else begin
                state_d = ST_IDLE;
              end
            end
          endcase
        end else begin
          vc_d = vc_q + 1'b1;
        end
      end
    end
    if (relatch) begin
      mode_d  = i_mode;
      solid_d = i_solid_rgb;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      hc_q    <= '0;
      vc_q    <= '0;
      mode_q  <= MODE_BARS;
      solid_q <= 12'h000;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
    end
  end

  assign pix_x = XW'(hc_q >> 1);

  dvp_pattern_gen #(
    .H_ACTIVE   (H_ACTIVE),
    .CHECK_LOG2 (CHECK_LOG2),
    .XW         (XW),
    .YW         (VW)
  ) u_gen (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_mode      (mode_q),
    .i_x         (pix_x),
    .i_y         (vc_q),
    .i_solid_rgb (solid_q),
    .o_rgb       (rgb_s1)
  );

  // Strobes get the same one-cycle delay as the generator so every output lines up.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vsync_s1_q <= 1'b0;
      href_s1_q  <= 1'b0;
      odd_s1_q   <= 1'b0;
      busy_s1_q  <= 1'b0;
      done_s1_q  <= 1'b0;
      pix_q      <= 8'h00;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      busy_q     <= 1'b0;
      fcnt_q     <= 16'h0000;
    end else begin
      vsync_s1_q <= (state_q == ST_VSYNC);
      href_s1_q  <= (state_q == ST_ACTIVE) && (hc_q < HW'(2 * H_ACTIVE));
      odd_s1_q   <= hc_q[0];
      busy_s1_q  <= (state_q != ST_IDLE);
      done_s1_q  <= frame_done;
      pix_q      <= href_s1_q ? pack_rgb444(rgb_s1, odd_s1_q) : 8'h00;
      vsync_q    <= vsync_s1_q;
      href_q     <= href_s1_q;
      busy_q     <= busy_s1_q;
      if (done_s1_q) fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign o_pix_byte  = pix_q;
  assign o_vsync     = vsync_q;
  assign o_href      = href_q;
  assign o_busy      = busy_q;
  assign o_frame_cnt = fcnt_q;

endmodule
